// File: rtl/tetris_pkg.sv
// Shared playfield geometry, pixel type and palette for the
// Tetris display path.
package tetris_pkg;

    localparam int GRID_W = 10;
    localparam int GRID_H = 20;
    localparam int CELLS  = GRID_W * GRID_H;

    typedef logic [11:0] rgb444_t;

    localparam rgb444_t BLACK      = 12'h000;
    localparam rgb444_t BORDER     = 12'hFFF;
    localparam rgb444_t BORDER_GO  = 12'hF00;
    localparam rgb444_t GRIDLINE   = 12'h333;
    localparam rgb444_t CELL_ON    = 12'h0FF;
    localparam rgb444_t CELL_FLASH = 12'hFFF;

    // Row-major bit position of a cell in the playfield bus.
    function automatic logic [7:0] cell_idx(
        input logic [4:0] row,
        input logic [3:0] col
    );
        return 8'(row) * 8'(GRID_W) + 8'(col);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-enable divider, h/v raster counters and raw sync/de/frame-start
// generation; all outputs are combinational from the counters.
module vga_timing #(
    parameter int PIX_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pe,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       h_last,
    output logic       hs_raw,
    output logic       vs_raw,
    output logic       de_raw,
    output logic       fs_raw
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;
    localparam int DW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    logic [DW-1:0] div;
    logic          v_last;

    assign pe     = (div == DW'(PIX_DIV - 1));
    assign h_last = (h_cnt == 10'(H_TOTAL - 1));
    assign v_last = (v_cnt == 10'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            div   <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pe) begin
            div   <= '0;
            h_cnt <= h_last ? 10'd0 : h_cnt + 10'd1;
            if (h_last) begin
                v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
            end
        end else begin
            div <= div + DW'(1);
        end
    end

    assign hs_raw = !((h_cnt >= 10'(HS_START)) && (h_cnt <= 10'(HS_END)));
    assign vs_raw = !((v_cnt >= 10'(VS_START)) && (v_cnt <= 10'(VS_END)));
    assign de_raw = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
    assign fs_raw = (h_cnt == 10'd0) && (v_cnt == 10'd0);

endmodule

// File: rtl/tetris_vga_renderer.sv
// Rasterises the snapshotted 10x20 playfield onto VGA with border,
// grid lines, line-clear flash and game-over border colour.
module tetris_vga_renderer
    import tetris_pkg::*;
#(
    parameter int PIX_DIV      = 2,
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int CELL         = 20,
    parameter int ORIGIN_X     = 220,
    parameter int ORIGIN_Y     = 40,
    parameter int FLASH_FRAMES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CELLS-1:0] grid_state,
    input  logic             row_cleared,
    input  logic             game_over,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [3:0]       r,
    output logic [3:0]       g,
    output logic [3:0]       b,
    output logic             frame_start
);

    localparam int PF_X1 = ORIGIN_X + GRID_W * CELL;
    localparam int PF_Y1 = ORIGIN_Y + GRID_H * CELL;
    localparam int RX0   = ORIGIN_X - 2;
    localparam int RX1   = PF_X1 + 1;
    localparam int RY0   = ORIGIN_Y - 2;
    localparam int RY1   = PF_Y1 + 1;
    localparam int CW    = $clog2(CELL);
    localparam int FW    = $clog2(FLASH_FRAMES + 1);

    logic             pe;
    logic             h_last;
    logic             hs_raw;
    logic             vs_raw;
    logic             de_raw;
    logic             fs_raw;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic [CW-1:0]    cx_px;
    logic [CW-1:0]    cy_px;
    logic [3:0]       cx_col;
    logic [4:0]       cy_row;
    logic [CELLS-1:0] grid_snap;
    logic             go_snap;
    logic [FW-1:0]    flash_cnt;
    logic             in_box;
    logic             in_play;
    logic             occupied;
    logic             border_hit;
    logic             line_hit;
    logic             cell_hit;
    rgb444_t          pix;
    rgb444_t          rgb_q;

    vga_timing #(
        .PIX_DIV  (PIX_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk    (clk),
        .reset  (reset),
        .pe     (pe),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .h_last (h_last),
        .hs_raw (hs_raw),
        .vs_raw (vs_raw),
        .de_raw (de_raw),
        .fs_raw (fs_raw)
    );

    // Cell walk: re-zeroed one pixel/line before the playfield edge
    // so it reads 0 exactly on the first playfield column/row.
    always_ff @(posedge clk) begin
        if (reset) begin
            cx_px  <= '0;
            cx_col <= '0;
            cy_px  <= '0;
            cy_row <= '0;
        end else if (pe) begin
            if (h_cnt == 10'(ORIGIN_X - 1)) begin
                cx_px  <= '0;
                cx_col <= '0;
            end else if (cx_px == CW'(CELL - 1)) begin
                cx_px  <= '0;
                cx_col <= (cx_col == 4'(GRID_W - 1)) ? 4'd0 : cx_col + 4'd1;
            end else begin
                cx_px <= cx_px + CW'(1);
            end
            if (h_last) begin
                if (v_cnt == 10'(ORIGIN_Y - 1)) begin
                    cy_px  <= '0;
                    cy_row <= '0;
                end else if (cy_px == CW'(CELL - 1)) begin
                    cy_px  <= '0;
                    cy_row <= (cy_row == 5'(GRID_H - 1)) ? 5'd0 : cy_row + 5'd1;
                end else begin
                    cy_px <= cy_px + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grid_snap <= '0;
            go_snap   <= 1'b0;
        end else if (pe && h_cnt == 10'd0 && v_cnt == 10'(V_ACTIVE)) begin
            grid_snap <= grid_state;
            go_snap   <= game_over;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flash_cnt <= '0;
        end else if (row_cleared) begin
            flash_cnt <= FW'(FLASH_FRAMES);
        end else if (frame_start && flash_cnt != '0) begin
            flash_cnt <= flash_cnt - FW'(1);
        end
    end

    assign in_box = (h_cnt >= 10'(RX0)) && (h_cnt <= 10'(RX1)) &&
                    (v_cnt >= 10'(RY0)) && (v_cnt <= 10'(RY1));
    assign in_play = (h_cnt >= 10'(ORIGIN_X)) && (h_cnt < 10'(PF_X1)) &&
                     (v_cnt >= 10'(ORIGIN_Y)) && (v_cnt < 10'(PF_Y1));
    assign occupied   = grid_snap[cell_idx(cy_row, cx_col)];
    assign border_hit = in_box && !in_play;
    assign line_hit   = in_play && (cx_px == '0 || cy_px == '0);
    assign cell_hit   = in_play && !line_hit && occupied;

    always_comb begin
        pix = BLACK;
        unique case (1'b1)
            border_hit: pix = go_snap ? BORDER_GO : BORDER;
            line_hit:   pix = GRIDLINE;
            cell_hit:   pix = (flash_cnt != '0) ? CELL_FLASH : CELL_ON;
            default:    pix = BLACK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            rgb_q       <= BLACK;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pe) begin
                hsync       <= hs_raw;
                vsync       <= vs_raw;
                de          <= de_raw;
                rgb_q       <= de_raw ? pix : BLACK;
                frame_start <= fs_raw;
            end
        end
    end

    assign r = rgb_q[11:8];
    assign g = rgb_q[7:4];
    assign b = rgb_q[3:0];

endmodule

// File: tb/tb_tetris_vga_renderer.sv
// Scoreboard bench: a pixel-index reference model predicts every output
// clock; a negedge monitor pops and compares.
module tb_tetris_vga_renderer;

    localparam int PD   = 2;
    localparam int HA   = 28;
    localparam int HFP  = 2;
    localparam int HS   = 4;
    localparam int HBP  = 2;
    localparam int VA   = 48;
    localparam int VFP  = 1;
    localparam int VS   = 2;
    localparam int VBP  = 1;
    localparam int CELL = 2;
    localparam int OX   = 4;
    localparam int OY   = 4;
    localparam int FF   = 8;
    localparam int HT   = HA + HFP + HS + HBP;
    localparam int VT   = VA + VFP + VS + VBP;
    localparam int FT   = HT * VT;
    localparam int FCLK = FT * PD;

    typedef struct {
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [11:0] rgb;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [199:0] grid_state = '0;
    logic         row_cleared = 1'b0;
    logic         game_over = 1'b0;
    logic         hsync;
    logic         vsync;
    logic         de;
    logic [3:0]   r;
    logic [3:0]   g;
    logic [3:0]   b;
    logic         frame_start;

    exp_t         q[$];
    int           checks = 0;
    int           failures = 0;
    int           sc = 0;

    int           mn = 0;
    int           mfl = 0;
    logic [199:0] msnap = '0;
    logic         mgo = 1'b0;
    logic         mfs_prev = 1'b0;
    exp_t         mlast;

    tetris_vga_renderer #(
        .PIX_DIV      (PD),
        .H_ACTIVE     (HA),
        .H_FP         (HFP),
        .H_SYNC       (HS),
        .H_BP         (HBP),
        .V_ACTIVE     (VA),
        .V_FP         (VFP),
        .V_SYNC       (VS),
        .V_BP         (VBP),
        .CELL         (CELL),
        .ORIGIN_X     (OX),
        .ORIGIN_Y     (OY),
        .FLASH_FRAMES (FF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .grid_state  (grid_state),
        .row_cleared (row_cleared),
        .game_over   (game_over),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .r           (r),
        .g           (g),
        .b           (b),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] colour(int x, int y, logic [199:0] s,
                                           logic go, int fc);
        bit in_box;
        bit in_pf;
        in_box = x >= OX - 2 && x <= OX + 10 * CELL + 1 &&
                 y >= OY - 2 && y <= OY + 20 * CELL + 1;
        in_pf  = x >= OX && x < OX + 10 * CELL &&
                 y >= OY && y < OY + 20 * CELL;
        if (in_box && !in_pf) return go ? 12'hF00 : 12'hFFF;
        if (!in_pf) return 12'h000;
        if ((x - OX) % CELL == 0 || (y - OY) % CELL == 0) return 12'h333;
        if (s[((y - OY) / CELL) * 10 + (x - OX) / CELL])
            return (fc != 0) ? 12'hFFF : 12'h0FF;
        return 12'h000;
    endfunction

    // Reference: after the n-th edge since reset release the outputs
    // show pixel (n-PD)/PD of the endless raster.
    always @(posedge clk) begin : model
        exp_t e;
        int   p;
        int   h;
        int   v;
        e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.fs = 1'b0; e.rgb = 12'h000;
        if (reset) begin
            mn = 0; mfl = 0; msnap = '0; mgo = 1'b0; mfs_prev = 1'b0;
        end else begin
            mn++;
            if (mn >= PD) begin
                if ((mn - PD) % PD == 0) begin
                    p = ((mn - PD) / PD) % FT;
                    v = p / HT;
                    h = p % HT;
                    e.hs  = !(h >= HA + HFP && h < HA + HFP + HS);
                    e.vs  = !(v >= VA + VFP && v < VA + VFP + VS);
                    e.de  = (h < HA) && (v < VA);
                    e.rgb = e.de ? colour(h, v, msnap, mgo, mfl) : 12'h000;
                    e.fs  = (p == 0);
                    mlast = e;
                    if (p == VA * HT) begin
                        msnap = grid_state;
                        mgo   = game_over;
                    end
                end else begin
                    e    = mlast;
                    e.fs = 1'b0;
                end
            end
            if (row_cleared) mfl = FF;
            else if (mfs_prev && mfl > 0) mfl--;
            mfs_prev = e.fs;
        end
        q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({hsync, vsync, de, frame_start, r, g, b} !==
                {e.hs, e.vs, e.de, e.fs, e.rgb}) begin
                failures++;
                $display("FAIL out t=%0t got hs=%b vs=%b de=%b fs=%b rgb=%03h want hs=%b vs=%b de=%b fs=%b rgb=%03h",
                         $time, hsync, vsync, de, frame_start, {r, g, b},
                         e.hs, e.vs, e.de, e.fs, e.rgb);
            end
        end
    end

    function automatic logic [199:0] rand_grid();
        logic [223:0] t;
        for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom();
        return t[199:0];
    endfunction

    task automatic tick(input bit churn);
        @(negedge clk);
        sc++;
        if (churn && $urandom_range(0, 299) == 0) grid_state = rand_grid();
        if (churn && $urandom_range(0, 2999) == 0) game_over = ~game_over;
    endtask

    task automatic run(input int n);
        repeat (n) tick(1'b1);
    endtask

    task automatic pulse_clear(input int w);
        row_cleared = 1'b1;
        repeat (w) tick(1'b0);
        row_cleared = 1'b0;
    endtask

    task automatic wait_line(input int line);
        int guard = 0;
        while (!(sc >= PD && ((sc - PD) / PD) % FT == line * HT) &&
               guard < 2 * FCLK) begin
            tick(1'b1);
            guard++;
        end
        checks++;
        if (guard >= 2 * FCLK) begin
            failures++;
            $display("FAIL wait_line(%0d) expired t=%0t", line, $time);
        end
    endtask

    task automatic chk_reset();
        checks++;
        if ({hsync, vsync, de, frame_start, r, g, b} !==
            {1'b1, 1'b1, 1'b0, 1'b0, 12'h000}) begin
            failures++;
            $display("FAIL reset t=%0t hs=%b vs=%b de=%b fs=%b rgb=%03h",
                     $time, hsync, vsync, de, frame_start, {r, g, b});
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        grid_state      = rand_grid();
        grid_state[0]   = 1'b1;
        grid_state[199] = 1'b1;
        reset = 1'b0;
        sc    = 0;
        run(FCLK + 50);
        wait_line(20);
        game_over = 1'b1;
        pulse_clear(1);
        run(5 * FCLK - 1);
        pulse_clear(3);
        run(9 * FCLK);
        game_over = 1'b0;
        wait_line(30);
        reset = 1'b1;
        tick(1'b0);
        chk_reset();
        reset = 1'b0;
        sc    = 0;
        run(2 * FCLK + 100);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
